// File: rtl/store_mem_data_pkg.sv
// Shared constants and helpers for the MEM-stage store-data lane aligner.
package store_mem_data_pkg;

  localparam int unsigned LANES = 4;

  localparam logic [LANES-1:0] BE_WORD    = 4'b1111;
  localparam logic [LANES-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [LANES-1:0] BE_HALF_HI = 4'b1100;
  localparam logic [LANES-1:0] BE_B0      = 4'b0001;
  localparam logic [LANES-1:0] BE_B1      = 4'b0010;
  localparam logic [LANES-1:0] BE_B2      = 4'b0100;
  localparam logic [LANES-1:0] BE_B3      = 4'b1000;
  localparam logic [LANES-1:0] BE_NONE    = 4'b0000;

  // BE_NONE is legal: it encodes "no store" rather than an error.
  function automatic logic be_legal(input logic [LANES-1:0] be);
    logic legal;
    case (be)
      BE_WORD, BE_HALF_LO, BE_HALF_HI,
      BE_B0, BE_B1, BE_B2, BE_B3, BE_NONE: legal = 1'b1;
      default:                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/store_mem_data_lane_mux.sv
// Combinational lane placement of store data and byte-enable legality decode.
module store_lane_mux
  import store_mem_data_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter bit          ZERO_UNUSED = 1'b1
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [LANES-1:0]  i_byteen,
  output logic [DATA_W-1:0] o_lane_data,
  output logic              o_legal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [DATA_W-1:0] w_byte_rep;
  logic [DATA_W-1:0] w_half_rep;

  assign w_byte     = i_data[7:0];
  assign w_half     = i_data[15:0];
  assign w_byte_rep = {4{w_byte}};
  assign w_half_rep = {2{w_half}};
  assign o_legal    = be_legal(i_byteen);

  always_comb begin
    o_lane_data = '0;
    case (i_byteen)
      BE_WORD:    o_lane_data = i_data;
      BE_HALF_LO: o_lane_data = ZERO_UNUSED ? {16'h0000, w_half} : w_half_rep;
      BE_HALF_HI: o_lane_data = ZERO_UNUSED ? {w_half, 16'h0000} : w_half_rep;
      BE_B0:      o_lane_data = ZERO_UNUSED ? {24'h000000, w_byte} : w_byte_rep;
      BE_B1:      o_lane_data = ZERO_UNUSED ? {16'h0000, w_byte, 8'h00} : w_byte_rep;
      BE_B2:      o_lane_data = ZERO_UNUSED ? {8'h00, w_byte, 16'h0000} : w_byte_rep;
      BE_B3:      o_lane_data = ZERO_UNUSED ? {w_byte, 24'h000000} : w_byte_rep;
      // BE_NONE and illegal patterns carry no data.
      default:    o_lane_data = '0;
    endcase
  end

endmodule

// File: rtl/store_mem_data.sv
// MEM-stage store-data aligner: lane decode plus one register stage toward the data bus.
module store_mem_data
  import store_mem_data_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter bit          ZERO_UNUSED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] Read2_M,
  input  logic [LANES-1:0]  m_data_byteen,
  output logic [DATA_W-1:0] m_data_wdata,
  output logic [LANES-1:0]  m_data_byteen_q,
  output logic              valid_out,
  output logic              byteen_err
);

  logic [DATA_W-1:0] w_lane_data;
  logic              w_legal;
  logic              w_accept;

  logic [DATA_W-1:0] r_wdata;
  logic [LANES-1:0]  r_byteen;
  logic              r_valid;
  logic              r_err;

  store_lane_mux #(
    .DATA_W      (DATA_W),
    .ZERO_UNUSED (ZERO_UNUSED)
  ) u_lane_mux (
    .i_data      (Read2_M),
    .i_byteen    (m_data_byteen),
    .o_lane_data (w_lane_data),
    .o_legal     (w_legal)
  );

  assign w_accept = valid_in & w_legal;

  // Write data registers unconditionally; only the qualifiers depend on valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdata  <= '0;
      r_byteen <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_wdata  <= w_lane_data;
      r_byteen <= w_accept ? m_data_byteen : '0;
      r_valid  <= w_accept;
      r_err    <= valid_in & ~w_legal;
    end
  end

  assign m_data_wdata    = r_wdata;
  assign m_data_byteen_q = r_byteen;
  assign valid_out       = r_valid;
  assign byteen_err      = r_err;

endmodule

// File: tb/tb_store_mem_data.sv
// Randomized self-checking bench for store_mem_data, both lane-fill modes side by side.
module tb_store_mem_data;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] read2;
  logic [3:0]  byteen;

  logic [31:0] wdata_z, wdata_r;
  logic [3:0]  beq_z, beq_r;
  logic        vout_z, vout_r;
  logic        err_z, err_r;

  int n_tests;
  int n_fail;

  store_mem_data #(.DATA_W(32), .ZERO_UNUSED(1'b1)) u_dut_z (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_in        (valid_in),
    .Read2_M         (read2),
    .m_data_byteen   (byteen),
    .m_data_wdata    (wdata_z),
    .m_data_byteen_q (beq_z),
    .valid_out       (vout_z),
    .byteen_err      (err_z)
  );

  store_mem_data #(.DATA_W(32), .ZERO_UNUSED(1'b0)) u_dut_r (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_in        (valid_in),
    .Read2_M         (read2),
    .m_data_byteen   (byteen),
    .m_data_wdata    (wdata_r),
    .m_data_byteen_q (beq_r),
    .valid_out       (vout_r),
    .byteen_err      (err_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Legal = empty, or an aligned run of 1, 2 or 4 lanes.
  function automatic bit model_legal(input logic [3:0] be);
    int n;
    int lo;
    logic [3:0] run;
    if (be == 4'b0000) return 1'b1;
    n  = $countones(be);
    lo = 0;
    while (be[lo] == 1'b0) lo++;
    run = 4'(((1 << n) - 1) << lo);
    return (n == 1 || n == 2 || n == 4) && (lo % n == 0) && (be == run);
  endfunction

  function automatic logic [31:0] model_data(input logic [3:0] be, input logic [31:0] d,
                                             input bit zero_fill);
    int n;
    int lo;
    logic [31:0] unit;
    logic [31:0] res;
    if (be == 4'b0000 || !model_legal(be)) return 32'h0;
    n  = $countones(be);
    lo = 0;
    while (be[lo] == 1'b0) lo++;
    unit = (n == 4) ? d : (d & ((32'h1 << (8 * n)) - 32'h1));
    if (zero_fill) return unit << (8 * lo);
    res = 32'h0;
    for (int k = 0; k < 4; k += n) res = res | (unit << (8 * k));
    return res;
  endfunction

  task automatic check_outputs(input string tag, input bit v, input logic [31:0] d,
                               input logic [3:0] be);
    bit ok;
    ok = v && model_legal(be);
    check_eq({tag, " z.wdata"}, wdata_z, model_data(be, d, 1'b1));
    check_eq({tag, " r.wdata"}, wdata_r, model_data(be, d, 1'b0));
    check_eq({tag, " z.beq"}, {28'h0, beq_z}, ok ? {28'h0, be} : 32'h0);
    check_eq({tag, " r.beq"}, {28'h0, beq_r}, ok ? {28'h0, be} : 32'h0);
    check_eq({tag, " z.vout"}, {31'h0, vout_z}, {31'h0, ok});
    check_eq({tag, " r.vout"}, {31'h0, vout_r}, {31'h0, ok});
    check_eq({tag, " z.err"}, {31'h0, err_z}, {31'h0, v && !model_legal(be)});
    check_eq({tag, " r.err"}, {31'h0, err_r}, {31'h0, v && !model_legal(be)});
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, " z.wdata"}, wdata_z, 32'h0);
    check_eq({tag, " r.wdata"}, wdata_r, 32'h0);
    check_eq({tag, " z.flags"}, {25'h0, beq_z, vout_z, err_z, 1'b0}, 32'h0);
    check_eq({tag, " r.flags"}, {25'h0, beq_r, vout_r, err_r, 1'b0}, 32'h0);
  endtask

  task automatic apply(input string tag, input bit v, input logic [31:0] d,
                       input logic [3:0] be);
    @(negedge clk);
    valid_in = v;
    read2    = d;
    byteen   = be;
    @(posedge clk);
    #1;
    check_outputs(tag, v, d, be);
  endtask

  initial begin
    logic [3:0] legal_pats [8];
    logic [3:0] be;
    n_tests  = 0;
    n_fail   = 0;
    legal_pats = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    rst_n    = 1'b0;
    valid_in = 1'b1;
    read2    = 32'hFFFF_FFFF;
    byteen   = 4'b1111;
    #1;
    check_zero("reset");
    @(posedge clk);
    #1;
    check_zero("reset held");
    @(negedge clk);
    rst_n = 1'b1;

    apply("word", 1'b1, 32'h12345678, 4'b1111);
    apply("half lo", 1'b1, 32'hAABBCCDD, 4'b0011);
    apply("half hi", 1'b1, 32'hAABBCCDD, 4'b1100);
    apply("byte0", 1'b1, 32'hAABBCCDD, 4'b0001);
    apply("byte1", 1'b1, 32'hAABBCCDD, 4'b0010);
    apply("byte2", 1'b1, 32'hAABBCCDD, 4'b0100);
    apply("byte3", 1'b1, 32'hAABBCCDD, 4'b1000);
    apply("illegal", 1'b1, 32'hAABBCCDD, 4'b0110);
    apply("after illegal", 1'b1, 32'h0000005A, 4'b0100);
    apply("no store", 1'b1, 32'h87654321, 4'b0000);
    apply("invalid word", 1'b0, 32'hCAFEF00D, 4'b1111);
    apply("invalid illegal", 1'b0, 32'hCAFEF00D, 4'b1011);
    apply("pre-reset", 1'b1, 32'hDEADBEEF, 4'b1111);

    // Asynchronous reset mid-cycle with non-zero outputs.
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async reset");
    @(negedge clk);
    valid_in = 1'b1;
    read2    = 32'h13572468;
    byteen   = 4'b1100;
    rst_n    = 1'b1;
    #1;
    check_zero("post release");
    @(posedge clk);
    #1;
    check_outputs("first after reset", 1'b1, 32'h13572468, 4'b1100);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) be = legal_pats[$urandom_range(0, 7)];
      else be = 4'($urandom_range(0, 15));
      apply("random", $urandom_range(0, 3) != 0, $urandom, be);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
